rf_wb_arbiter: RTL and testbench

Controller for the 32×32 register file's single write port. After reset, it runs a clear sequence that writes zero to registers x1..x31. It then shares the write port between two writeback requesters, the ALU and the load unit, using round-robin arbitration and valid/ready handshakes. Its registered outputs drive the register file's write-enable, write-address and write-data inputs directly.

---
 rtl/rf_ctrl_pkg.sv | 18 +
 rtl/rr_arb2.sv | 36 +++
 rtl/rf_wb_arbiter.sv | 109 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared parameters and encodings for the register-file
// write-port controller.
package rf_ctrl_pkg;
   localparam int XLEN     = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam int STALL_W  = 16;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_MEM = 1'b1
   } gnt_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the ALU,
// bit 1 the load unit.
module rr_arb2
   import rf_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   gnt_t lastGrant;

   always_comb begin
      gnt = 2'b00;
      if (enable) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (lastGrant == GNT_MEM) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Priority only moves on an accepted transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastGrant <= GNT_MEM;
      end else if (gnt[0]) begin
         lastGrant <= GNT_ALU;
      end else if (gnt[1]) begin
         lastGrant <= GNT_MEM;
      end
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: clears x1..x31 after
// reset, then arbitrates ALU and load writebacks.
module rf_wb_arbiter
   import rf_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               aluValid,
   output logic               aluReady,
   input  logic [ADDR_W-1:0]  aluRd,
   input  logic [XLEN-1:0]    aluData,
   input  logic               memValid,
   output logic               memReady,
   input  logic [ADDR_W-1:0]  memRd,
   input  logic [XLEN-1:0]    memData,
   output logic               regWriteEnable,
   output logic [ADDR_W-1:0]  writeReg,
   output logic [XLEN-1:0]    writeData,
   output logic               initDone,
   output logic [STALL_W-1:0] stallCount
);
   state_t state, nextState;
   logic [ADDR_W-1:0] idx;
   logic [1:0] gnt;
   logic running, lastIdx, stalled;
   logic nxtWe;
   logic [ADDR_W-1:0] nxtReg;
   logic [XLEN-1:0] nxtData;

   assign running = (state == RUN);
   assign lastIdx = (idx == ADDR_W'(NUM_REGS - 1));

   rr_arb2 uArb (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (running),
      .req    ({memValid, aluValid}),
      .gnt    (gnt)
   );

   assign aluReady = gnt[0];
   assign memReady = gnt[1];
   assign stalled  = running &&
                     ((aluValid && !aluReady) ||
                      (memValid && !memReady));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         INIT: if (lastIdx) nextState = RUN;
         RUN:  nextState = RUN;
         default: nextState = INIT;
      endcase
   end

   // x0 transfers are consumed but never enable a write.
   always_comb begin
      nxtWe   = 1'b0;
      nxtReg  = writeReg;
      nxtData = writeData;
      if (!running) begin
         nxtWe   = 1'b1;
         nxtReg  = idx;
         nxtData = '0;
      end else begin
         unique case (1'b1)
            gnt[0]: begin
               nxtWe   = (aluRd != '0);
               nxtReg  = aluRd;
               nxtData = aluData;
            end
            gnt[1]: begin
               nxtWe   = (memRd != '0);
               nxtReg  = memRd;
               nxtData = memData;
            end
            default: nxtWe = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx            <= ADDR_W'(1);
         regWriteEnable <= 1'b0;
         writeReg       <= '0;
         writeData      <= '0;
         initDone       <= 1'b0;
         stallCount     <= '0;
      end else begin
         regWriteEnable <= nxtWe;
         writeReg       <= nxtReg;
         writeData      <= nxtData;
         if (!running && !lastIdx) idx <= idx + 1'b1;
         if (!running && lastIdx) initDone <= 1'b1;
         if (stalled && stallCount != '1) begin
            stallCount <= stallCount + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: clear sequence, directed vectors,
// randomized traffic against a reference model, mid-run reset.
module tb_rf_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        aluValid, memValid;
   logic        aluReady, memReady;
   logic [4:0]  aluRd, memRd;
   logic [31:0] aluData, memData;
   logic        regWriteEnable;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic        initDone;
   logic [15:0] stallCount;

   int nChecks = 0;
   int nErr = 0;

   logic [31:0] rf [32];
   logic [31:0] mRf [32];

   typedef struct {
      logic        av;
      logic [4:0]  ar;
      logic [31:0] ad;
      logic        mv;
      logic [4:0]  mr;
      logic [31:0] md;
      logic        eA;
      logic        eM;
      logic        eWe;
      logic [4:0]  eReg;
      logic [31:0] eData;
      logic [15:0] eStall;
   } vec_t;

   vec_t tbl [9];

   always #5 clk = ~clk;

   rf_wb_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .aluValid       (aluValid),
      .aluReady       (aluReady),
      .aluRd          (aluRd),
      .aluData        (aluData),
      .memValid       (memValid),
      .memReady       (memReady),
      .memRd          (memRd),
      .memData        (memData),
      .regWriteEnable (regWriteEnable),
      .writeReg       (writeReg),
      .writeData      (writeData),
      .initDone       (initDone),
      .stallCount     (stallCount)
   );

   // Register file stand-in fed by the DUT outputs.
   always @(posedge clk) begin
      if (regWriteEnable && writeReg != 5'd0) begin
         rf[writeReg] <= writeData;
      end
   end

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ar,
                        input logic [31:0] ad, input logic mv,
                        input logic [4:0] mr, input logic [31:0] md);
      aluValid = av;
      aluRd    = ar;
      aluData  = ad;
      memValid = mv;
      memRd    = mr;
      memData  = md;
   endtask

   task automatic checkZeroOutputs(input string tag);
      chk({tag, " we"}, 32'(regWriteEnable), 32'd0);
      chk({tag, " reg"}, 32'(writeReg), 32'd0);
      chk({tag, " data"}, writeData, 32'd0);
      chk({tag, " initDone"}, 32'(initDone), 32'd0);
      chk({tag, " stall"}, 32'(stallCount), 32'd0);
      chk({tag, " readies"}, 32'({aluReady, memReady}), 32'd0);
   endtask

   // Valids held high throughout to show INIT never grants.
   task automatic runInit(input string tag);
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
      for (int k = 1; k <= 31; k++) begin
         chk({tag, " init readies"}, 32'({aluReady, memReady}), 32'd0);
         @(posedge clk);
         #1;
         chk({tag, " init we"}, 32'(regWriteEnable), 32'd1);
         chk({tag, " init reg"}, 32'(writeReg), 32'(k));
         chk({tag, " init data"}, writeData, 32'd0);
         chk({tag, " init done"}, 32'(initDone), 32'(k == 31));
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk({tag, " stall after init"}, 32'(stallCount), 32'd0);
   endtask

   // Reference model state
   int mLast;
   int mStall;
   logic mWe;
   logic [4:0] mReg;
   logic [31:0] mData;

   initial begin
      logic av, mv, ga, gm, aHold, mHold;
      logic [4:0] ar, mr;
      logic [31:0] ad, md;

      for (int i = 0; i < 32; i++) rf[i] = 32'hFFFF_FFFF;
      rf[0] = 32'd0;
      rst_n = 1'b0;
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
      #12;
      checkZeroOutputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      runInit("boot");

      @(posedge clk);
      #1;
      chk("clear x0..x31", 32'(rf.sum() with (int'(item != 0))), 32'd0);

      tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,
                 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 16'd0};
      tbl[1] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55,
                 1'b0, 1'b1, 1'b0, 5'd0, 32'h55, 16'd0};
      tbl[2] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44,
                 1'b1, 1'b0, 1'b1, 5'd3, 32'h33, 16'd1};
      tbl[3] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44,
                 1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 16'd2};
      tbl[4] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44,
                 1'b1, 1'b0, 1'b1, 5'd3, 32'h33, 16'd3};
      tbl[5] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44,
                 1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 16'd4};
      tbl[6] = '{1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2,
                 1'b1, 1'b0, 1'b1, 5'd7, 32'd1, 16'd5};
      tbl[7] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd2,
                 1'b0, 1'b1, 1'b1, 5'd7, 32'd2, 16'd5};
      tbl[8] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 5'd7, 32'd2, 16'd5};

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].av, tbl[i].ar, tbl[i].ad,
               tbl[i].mv, tbl[i].mr, tbl[i].md);
         @(negedge clk);
         chk($sformatf("vec%0d aluReady", i), 32'(aluReady), 32'(tbl[i].eA));
         chk($sformatf("vec%0d memReady", i), 32'(memReady), 32'(tbl[i].eM));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d we", i), 32'(regWriteEnable), 32'(tbl[i].eWe));
         chk($sformatf("vec%0d reg", i), 32'(writeReg), 32'(tbl[i].eReg));
         chk($sformatf("vec%0d data", i), writeData, tbl[i].eData);
         chk($sformatf("vec%0d stall", i), 32'(stallCount), 32'(tbl[i].eStall));
      end
      chk("readback x5", rf[5], 32'hDEADBEEF);
      chk("readback x3", rf[3], 32'h33);
      chk("readback x4", rf[4], 32'h44);
      chk("readback x7", rf[7], 32'd2);
      chk("readback x0", rf[0], 32'd0);

      // Model picks up from the state the directed vectors left.
      for (int i = 0; i < 32; i++) mRf[i] = 32'd0;
      mRf[5] = 32'hDEADBEEF;
      mRf[3] = 32'h33;
      mRf[4] = 32'h44;
      mRf[7] = 32'd2;
      mLast = 1;
      mStall = 5;
      aHold = 1'b0;
      mHold = 1'b0;
      av = 1'b0; ar = '0; ad = '0;
      mv = 1'b0; mr = '0; md = '0;

      for (int c = 0; c < 400; c++) begin
         if (!aHold) begin
            av = ($urandom_range(0, 2) != 0);
            ar = 5'($urandom_range(0, 9));
            ad = $urandom;
         end
         if (!mHold) begin
            mv = ($urandom_range(0, 2) != 0);
            mr = 5'($urandom_range(0, 9));
            md = $urandom;
         end
         drive(av, ar, ad, mv, mr, md);
         if (av && mv) begin
            ga = (mLast == 1);
            gm = !ga;
         end else begin
            ga = av;
            gm = mv;
         end
         @(negedge clk);
         chk("rand aluReady", 32'(aluReady), 32'(ga));
         chk("rand memReady", 32'(memReady), 32'(gm));
         @(posedge clk);
         #1;
         if ((av && !ga) || (mv && !gm)) begin
            if (mStall < 65535) mStall++;
         end
         if (ga) begin
            mWe = (ar != 0); mReg = ar; mData = ad; mLast = 0;
            if (ar != 0) mRf[ar] = ad;
         end else if (gm) begin
            mWe = (mr != 0); mReg = mr; mData = md; mLast = 1;
            if (mr != 0) mRf[mr] = md;
         end else begin
            mWe = 1'b0;
         end
         chk("rand we", 32'(regWriteEnable), 32'(mWe));
         chk("rand reg", 32'(writeReg), 32'(mReg));
         chk("rand data", writeData, mData);
         chk("rand stall", 32'(stallCount), 32'(mStall));
         aHold = av && !ga;
         mHold = mv && !gm;
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("rand rf x%0d", i), rf[i], mRf[i]);
      end

      // Reset dropped in the middle of contention.
      drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkZeroOutputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      runInit("reinit");

      drive(1'b1, 5'd3, 32'hB3, 1'b1, 5'd4, 32'hB4);
      #1;
      chk("post-reset tie alu", 32'(aluReady), 32'd1);
      chk("post-reset tie mem", 32'(memReady), 32'd0);
      @(posedge clk);
      #1;
      chk("post-reset write reg", 32'(writeReg), 32'd3);
      chk("post-reset write data", writeData, 32'hB3);
      chk("post-reset stall", 32'(stallCount), 32'd1);

      $display("Result: errors=%0d of %0d checks", nErr, nChecks);
      $finish;
   end
endmodule
